// File: rtl/riv_rdy_vld_arb_pkg.sv
// Shared types and helpers for the round-robin packet-locked ready/valid arbiter.
package riv_rdy_vld_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req[n-1:0] searching upward from ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int unsigned         n);
        pick_t               res;
        logic [MAX_ID_W-1:0] j;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = MAX_ID_W'((32'(ptr) + k) % n);
            if (k < n && !res.found && req[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/riv_rdy_vld_out_reg.sv
// One-entry registered ready/valid stage; the producer may load whenever the
// slot is empty or is being drained in the same cycle.
module riv_rdy_vld_out_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] payload_i,
    input  logic         out_ready_i,
    output logic         can_load_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_payload_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] payload_q, payload_d;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load_i) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign can_load_o    = ~valid_q | out_ready_i;
    assign out_valid_o   = valid_q;
    assign out_payload_o = payload_q;

endmodule

// File: rtl/riv_rdy_vld_rr_arbiter.sv
// Round-robin arbiter that locks a grant for a whole packet and feeds a single
// registered ready/valid sink; also reports busy and a wrapping packet count.
module riv_rdy_vld_rr_arbiter
    import riv_rdy_vld_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned ID_W   = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        s_valid,
    output logic [N_REQ-1:0]        s_ready,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    input  logic [N_REQ-1:0]        s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic [ID_W-1:0]         m_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_count
);

    localparam int unsigned PW = ID_W + 1 + DATA_W;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [MAX_REQ-1:0] req_vec;
    pick_t              pick;
    logic               can_load;
    logic               accept;
    logic               beat_valid;
    logic               beat_last;
    logic [DATA_W-1:0]  beat_data;
    logic [PW-1:0]      out_payload;

    assign req_vec = MAX_REQ'(s_valid);
    assign pick    = rr_pick(req_vec, MAX_ID_W'(rr_ptr_q), N_REQ);

    always_comb begin
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_q) begin
                beat_valid = s_valid[i];
                beat_last  = s_last[i];
                beat_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration happens only in IDLE; a grant stays put until its last beat is taken.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        s_ready   = '0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    grant_d = ID_W'(pick.idx);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_ready = N_REQ'(can_load) << grant_q;
                accept  = beat_valid & can_load;
                if (accept && beat_last) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    riv_rdy_vld_out_reg #(
        .W (PW)
    ) u_out_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (accept),
        .payload_i     ({grant_q, beat_last, beat_data}),
        .out_ready_i   (m_ready),
        .can_load_o    (can_load),
        .out_valid_o   (m_valid),
        .out_payload_o (out_payload)
    );

    assign {m_id, m_last, m_data} = out_payload;
    assign busy      = (state_q == ST_LOCKED);
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_riv_rdy_vld_rr_arbiter.sv
// Bench for riv_rdy_vld_rr_arbiter: cycle table, directed corner sequences and
// randomized traffic checked against a packet-level round-robin model.
module tb_riv_rdy_vld_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    s_valid = '0;
    logic [N-1:0]    s_ready;
    logic [N*DW-1:0] s_data = '0;
    logic [N-1:0]    s_last = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [1:0]      m_id;
    logic            busy;
    logic [CW-1:0]   pkt_count;

    riv_rdy_vld_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_id(m_id), .busy(busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        rdy;
        logic [31:0] dat;
        logic [3:0]  e_srdy;
        logic        e_mv;
        logic [31:0] e_md;
        logic [1:0]  e_id;
        logic        e_ml;
        logic        e_busy;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[14];

    // Source-side beat queues ({last,data}) and the model's copy of the same traffic.
    logic [32:0] srcq[N][$];
    logic [32:0] expq[N][$];
    logic [34:0] obs[$];
    bit          inpkt[N];
    int          pos_cnt[N];
    int          gap_req, gap_beat, gap_len, gap_ctr;
    int          seq = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic rdy, logic [31:0] dat,
                                logic [3:0] srdy, logic mv, logic [31:0] md, logic [1:0] id,
                                logic ml, logic bsy, logic [3:0] cnt);
        vec_t r;
        r.v = v; r.l = l; r.rdy = rdy; r.dat = dat; r.e_srdy = srdy; r.e_mv = mv;
        r.e_md = md; r.e_id = id; r.e_ml = ml; r.e_busy = bsy; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [31:0] dat);
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = dat | (32'(i) << 28);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete(); expq[i].delete(); inpkt[i] = 0; pos_cnt[i] = 0;
        end
        obs.delete();
        gap_req = -1; gap_beat = 0; gap_len = 0; gap_ctr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add_pkt(input int r, input int len);
        logic [32:0] b;
        for (int k = 0; k < len; k++) begin
            seq++;
            b = {(k == len - 1), 4'(r), 28'(seq)};
            srcq[r].push_back(b);
            expq[r].push_back(b);
        end
    endtask

    // Drives preloaded packets and checks every consumed beat against a model that
    // picks the next packet as the first non-empty requester after the last winner.
    task automatic run_engine(input int max_cyc, input int rdy_pct, input int gap_pct);
        int          ptr = 0;
        int          cur = -1;
        int          npk = 0;
        int          cyc = 0;
        bit          all_empty;
        bit          prev_hold = 0;
        logic [N-1:0] acc;
        logic [34:0] held = '0;
        logic [32:0] e;
        forever begin
            all_empty = 1;
            for (int i = 0; i < N; i++) if (expq[i].size() != 0) all_empty = 0;
            if (all_empty) break;
            if (cyc >= max_cyc) begin
                chk("engine timeout", 64'(cyc), 64'(max_cyc + 1));
                break;
            end
            if (prev_hold) chk("held beat", {m_valid, m_id, m_last, m_data}, {1'b1, held});
            m_ready = ($urandom_range(99) < rdy_pct);
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() != 0) begin
                    s_valid[i] = 1'b1;
                    if (inpkt[i] && ($urandom_range(99) < gap_pct)) s_valid[i] = 1'b0;
                    if (i == gap_req && pos_cnt[i] == gap_beat && gap_ctr < gap_len) begin
                        s_valid[i] = 1'b0;
                        gap_ctr++;
                    end
                    s_data[i*DW +: DW] = srcq[i][0][31:0];
                    s_last[i] = srcq[i][0][32];
                end else begin
                    s_valid[i] = 1'b0;
                    s_last[i] = 1'($urandom);
                    s_data[i*DW +: DW] = $urandom;
                end
            end
            #1;
            acc = s_valid & s_ready;
            prev_hold = m_valid & ~m_ready;
            held = {m_id, m_last, m_data};
            if (m_valid && m_ready) begin
                if (cur < 0) begin
                    for (int k = 0; k < N; k++)
                        if (cur < 0 && expq[(ptr + k) % N].size() != 0) cur = (ptr + k) % N;
                end
                if (cur < 0) begin
                    chk("unexpected beat", {m_id, m_last, m_data}, 35'h0);
                end else begin
                    e = expq[cur].pop_front();
                    chk("beat id", 64'(m_id), 64'(cur));
                    chk("beat last/data", {m_last, m_data}, e);
                    obs.push_back({m_id, m_last, m_data});
                    if (e[32]) begin
                        ptr = (cur + 1) % N;
                        cur = -1;
                        npk++;
                    end
                end
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    e = srcq[i].pop_front();
                    inpkt[i] = !e[32];
                    pos_cnt[i]++;
                end
            end
            cyc++;
        end
        s_valid = '0;
        m_ready = 1'b1;
        repeat (3) step();
        chk("drained m_valid", 64'(m_valid), 64'h0);
        chk("pkt_count", 64'(pkt_count), 64'(npk % 16));
    endtask

    initial begin
        tbl[0]  = mk(4'b0100, 4'b0000, 1, 32'hA0, 4'b0000, 0, 32'h0,         2'd0, 0, 0, 4'd0);
        tbl[1]  = mk(4'b0100, 4'b0000, 1, 32'hA0, 4'b0100, 0, 32'h0,         2'd0, 0, 1, 4'd0);
        tbl[2]  = mk(4'b0100, 4'b0000, 1, 32'hA1, 4'b0100, 1, 32'h2000_00A0, 2'd2, 0, 1, 4'd0);
        tbl[3]  = mk(4'b0100, 4'b0100, 1, 32'hA2, 4'b0100, 1, 32'h2000_00A1, 2'd2, 0, 1, 4'd0);
        tbl[4]  = mk(4'b0000, 4'b0000, 1, 32'h00, 4'b0000, 1, 32'h2000_00A2, 2'd2, 1, 0, 4'd1);
        tbl[5]  = mk(4'b1111, 4'b1111, 1, 32'h05, 4'b0000, 0, 32'h0,         2'd0, 0, 0, 4'd1);
        tbl[6]  = mk(4'b1111, 4'b1111, 1, 32'h06, 4'b1000, 0, 32'h0,         2'd0, 0, 1, 4'd1);
        tbl[7]  = mk(4'b1111, 4'b1111, 1, 32'h07, 4'b0000, 1, 32'h3000_0006, 2'd3, 1, 0, 4'd2);
        tbl[8]  = mk(4'b1111, 4'b1111, 1, 32'h08, 4'b0001, 0, 32'h0,         2'd0, 0, 1, 4'd2);
        tbl[9]  = mk(4'b1111, 4'b1111, 0, 32'h09, 4'b0000, 1, 32'h0000_0008, 2'd0, 1, 0, 4'd3);
        tbl[10] = mk(4'b1111, 4'b1111, 0, 32'h0A, 4'b0000, 1, 32'h0000_0008, 2'd0, 1, 1, 4'd3);
        tbl[11] = mk(4'b1111, 4'b1111, 1, 32'h0B, 4'b0010, 1, 32'h0000_0008, 2'd0, 1, 1, 4'd3);
        tbl[12] = mk(4'b0000, 4'b0000, 1, 32'h00, 4'b0000, 1, 32'h1000_000B, 2'd1, 1, 0, 4'd4);
        tbl[13] = mk(4'b0000, 4'b0000, 1, 32'h00, 4'b0000, 0, 32'h0,         2'd0, 0, 0, 4'd4);

        // Reset state, observed asynchronously.
        #2 rst_n = 1'b0;
        #1;
        chk("reset m_valid", 64'(m_valid), 64'h0);
        chk("reset s_ready", 64'(s_ready), 64'h0);
        chk("reset outputs", {m_data, m_last, m_id, busy, pkt_count}, 64'h0);

        // Cycle-accurate table: single packet from req2, then rr pointer and backpressure.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            s_valid = tbl[k].v;
            s_last  = tbl[k].l;
            m_ready = tbl[k].rdy;
            set_lanes(tbl[k].dat);
            #1;
            chk($sformatf("tbl%0d s_ready", k), 64'(s_ready), 64'(tbl[k].e_srdy));
            chk($sformatf("tbl%0d m_valid", k), 64'(m_valid), 64'(tbl[k].e_mv));
            chk($sformatf("tbl%0d busy/cnt", k), {busy, pkt_count}, {tbl[k].e_busy, tbl[k].e_cnt});
            if (tbl[k].e_mv)
                chk($sformatf("tbl%0d beat", k), {m_id, m_last, m_data},
                    {tbl[k].e_id, tbl[k].e_ml, tbl[k].e_md});
            step();
        end

        // Fairness: every requester holds two single-beat packets.
        do_reset();
        for (int p = 0; p < 2; p++) for (int r = 0; r < N; r++) add_pkt(r, 1);
        run_engine(200, 100, 0);
        chk("fair count", 64'(obs.size()), 64'd8);
        for (int k = 0; k < obs.size(); k++) chk($sformatf("fair order %0d", k), 64'(obs[k][34:33]), 64'(k % 4));

        // Packet lock: req0 pauses after its first beat while req1 waits.
        do_reset();
        add_pkt(0, 4);
        add_pkt(1, 1);
        gap_req = 0; gap_beat = 1; gap_len = 3;
        run_engine(200, 100, 0);
        chk("lock count", 64'(obs.size()), 64'd5);
        for (int k = 0; k < obs.size(); k++) chk($sformatf("lock id %0d", k), 64'(obs[k][34:33]), (k < 4) ? 64'd0 : 64'd1);

        // Reset in the middle of a 3-beat packet from req2.
        do_reset();
        s_valid = 4'b0100; s_last = '0; m_ready = 1'b1;
        set_lanes(32'hB0);
        step();
        step();
        set_lanes(32'hB1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst m_valid", 64'(m_valid), 64'h0);
        chk("midrst s_ready/busy/cnt", {s_ready, busy, pkt_count}, 64'h0);
        s_valid = 4'b1111; s_last = 4'b1111;
        set_lanes(32'hC0);
        @(posedge clk);
        #1;
        chk("in-reset m_valid", 64'(m_valid), 64'h0);
        rst_n = 1'b1;
        step();
        chk("post-rst s_ready", 64'(s_ready), 64'b0001);
        step();
        chk("post-rst beat", {m_valid, m_id, m_data}, {1'b1, 2'd0, 32'h0000_00C0});
        s_valid = '0;

        // Counter wrap: 17 single-beat packets from one requester.
        do_reset();
        for (int p = 0; p < 17; p++) add_pkt(3, 1);
        run_engine(1000, 100, 0);
        chk("wrap pkt_count", 64'(pkt_count), 64'd1);

        // Randomized traffic with mid-packet gaps and sink backpressure.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int r = 0; r < N; r++) begin
                int np = $urandom_range(5, 1);
                for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(4, 1));
            end
            run_engine(3000, (round == 0) ? 40 : 75, 30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/riv_rdy_vld_rr_arbiter.md
Name: riv_rdy_vld_rr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares one ready/valid sink among N_REQ ready/valid requesters.
- Grant is held from a packet's first beat until its last beat is accepted.
- Output is registered (one-entry pipeline), so the sink sees clean timing.
- Sits between multiple riv ready/valid producers and a single shared downstream channel; also exposes grant and packet-count status.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 32, payload width in bits
CNT_W, 16, width of per-arbiter packet counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  N_REQ  per-requester valid
s_ready  out  N_REQ  per-requester ready
s_data  in  N_REQ*DATA_W  per-requester payload, requester i at [i*DATA_W +: DATA_W]
s_last  in  N_REQ  per-requester end-of-packet
m_valid  out  1  output valid (registered)
m_ready  in  1  output ready
m_data  out  DATA_W  output payload (registered)
m_last  out  1  output end-of-packet (registered)
m_id  out  $clog2(N_REQ)  source index of current m_data beat (registered)
busy  out  1  high while state is LOCKED
pkt_count  out  CNT_W  packets completed (wraps)

Behaviour:
- Reset (asynchronous, active-low, all state): state=IDLE, rr_ptr=0, grant_idx=0, m_valid=0, m_data=0, m_last=0, m_id=0, pkt_count=0, busy=0. s_ready=0 during reset.
- States: IDLE, LOCKED.
- IDLE:
  - All s_ready=0.
  - If any s_valid is high, register grant_idx = first requester with s_valid=1 searching from rr_ptr upward modulo N_REQ; next state is LOCKED.
  - No data transfers in IDLE. Arbitration costs exactly 1 cycle.
- LOCKED:
  - s_ready[grant_idx] = (~m_valid | m_ready). All other s_ready = 0.
  - Input accept: s_valid[grant_idx] & s_ready[grant_idx]. On accept, register m_data, m_last, m_id = grant_idx; set m_valid=1.
  - When accept is 0 and m_valid & m_ready, clear m_valid.
  - Throughput is one beat per cycle under continuous valid/ready; latency from accept to m_valid is 1 cycle.
- Packet end: accepting a beat with s_last=1 causes:
  - next state IDLE;
  - rr_ptr = (grant_idx+1) mod N_REQ;
  - pkt_count += 1, wrapping at 2^CNT_W.
  - The output register may still hold that last beat while IDLE re-arbitrates.
- Next grant: the new grant's first beat can be accepted once the previous m_valid beat drains or is simultaneously consumed (same ready rule).
- Requester deasserting s_valid mid-packet: grant is held and no other requester is served until its s_last beat is accepted.
- m_valid=1 & m_ready=0: m_data, m_last and m_id are held stable; s_ready for the granted requester is 0.
- Single requester active: it is re-granted after every packet, with 1 idle arbitration cycle between packets.
- Reset mid-packet: the packet is truncated; the output register is cleared and no partial beat is presented after reset.
- Unknowns: s_data, s_last and m_ready are ignored while the corresponding valid is low.

Decomposition:
- Package riv_rdy_vld_arb_pkg holds:
  - state enum (IDLE, LOCKED);
  - function rr_pick(req vector, ptr) returning an index plus a found flag;
  - localparam ID_W = $clog2(N_REQ), floored at 1.
- Sub-module riv_rdy_vld_out_reg: one-entry registered ready/valid output stage carrying {id, last, data}. The arbiter FSM and mux stay in the top.

Test Plan:
- Single packet: N_REQ=4, req2 sends 3 beats A0,A1,A2 (last on A2), m_ready=1.
  - s_ready[2] rises 1 cycle after s_valid[2].
  - m_data = A0,A1,A2 on consecutive cycles with m_id=2 and m_last only on A2.
  - pkt_count=1; rr_ptr=3.
- Round-robin fairness: all 4 requesters continuously valid with 1-beat packets.
  - Grant order 0,1,2,3,0,1.
  - After 8 packets, each m_id value has appeared exactly twice.
- Packet lock: req0 sends a 4-beat packet, drops s_valid for 3 cycles after beat 1; req1 valid throughout.
  - No req1 beat appears on m_data until req0's last beat.
  - Then m_id=1.
- Backpressure: m_ready=0 for 5 cycles mid-packet.
  - m_valid, m_data and m_id held constant; s_ready[grant]=0.
  - No beat lost or duplicated; beat count out equals beat count in.
- Reset mid-packet: assert rst_n=0 asynchronously after beat 1 of a 3-beat packet.
  - m_valid=0, s_ready=0 and pkt_count=0 immediately.
  - After release, the next arbitration starts from requester 0.
- pkt_count wrap: CNT_W=4, send 17 single-beat packets → pkt_count=1.
